// File: rtl/delay_arbiter_pkg.sv
// Shared types and default sizing for the delay arbiter.
package delay_arbiter_pkg;

  localparam int unsigned NREQ_DEFAULT = 4;
  localparam int unsigned W_DEFAULT    = 8;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

endpackage

// File: rtl/delay_arbiter_rr_pick.sv
// Combinational round-robin selector: first set pending bit at or above ptr, wrapping.
module rr_pick
  import delay_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT
) (
  input  logic [NREQ-1:0]         pending,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int unsigned IW = $clog2(NREQ);

  always_comb begin
    int unsigned j;
    logic        found;
    valid = |pending;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && pending[j]) begin
        idx   = IW'(j);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delay_arbiter.sv
// Shares one W-bit delay counter among NREQ requesters, granting round-robin
// and pulsing done[grant_id] once the latched delay has elapsed.
module delay_arbiter
  import delay_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  parameter int unsigned W    = W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*W-1:0]       delay_val,
  input  logic                    abort,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int unsigned IW = $clog2(NREQ);

  state_t          state;
  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] clr;
  logic [W-1:0]    cnt;
  logic [W-1:0]    d_lat;
  logic [IW-1:0]   ptr;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] id);
    if (32'(id) == NREQ - 1) return '0;
    return id + IW'(1);
  endfunction

  rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .pending(pending),
    .ptr    (ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  // The active requester's pending bit drops on completion or abort.
  always_comb begin
    clr = '0;
    if (state == COUNT && (abort || cnt == d_lat)) clr[grant_id] = 1'b1;
  end

  // A new strobe on the clearing edge re-arms the bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else          pending <= (pending & ~clr) | req;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      d_lat    <= '0;
      ptr      <= '0;
      grant_id <= '0;
      done     <= '0;
      busy     <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_idx;
            d_lat    <= delay_val[32'(pick_idx) * W +: W];
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= COUNT;
          end
        end
        COUNT: begin
          if (abort) begin
            ptr   <= next_ptr(grant_id);
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == d_lat) begin
            done[grant_id] <= 1'b1;
            busy           <= 1'b0;
            state          <= DONE;
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        DONE: begin
          ptr   <= next_ptr(grant_id);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
